// File: rtl/intercal_alu_seq_if.sv
// Command, ALU and result bundle for intercal_alu_seq.
// slave = sequencer side, master = environment (command source, ALU, result sink).
interface intercal_alu_seq_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic [3:0]  cmd_rep;
   logic [3:0]  alu_s;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_f;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_err;
   logic        busy;

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_rep, alu_f, res_ready,
      output cmd_ready, alu_s, alu_a, alu_b, res_valid, res_data, res_err, busy
   );

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_rep, alu_f, res_ready,
      input  cmd_ready, alu_s, alu_a, alu_b, res_valid, res_data, res_err, busy
   );
endinterface

// File: rtl/intercal_alu_seq.sv
// Iterating sequencer around an external combinational ALU; the result is fed back into A cmd_rep times.
// Define INTERCAL_ALU_SEQ_PIPE_EN to allow a new command to be accepted on the result handshake edge.
module intercal_alu_seq (
   input  logic              clk,
   input  logic              rst,
   intercal_alu_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

   state_t     state;
   logic [3:0] cnt;
   logic       illegal;
   logic       accept;
   logic       handshake;

`ifdef INTERCAL_ALU_SEQ_PIPE_EN
   assign bus.cmd_ready = (state == IDLE) || ((state == HOLD) && bus.res_ready);
`else
   assign bus.cmd_ready = (state == IDLE);
`endif

   assign accept    = bus.cmd_valid && bus.cmd_ready;
   assign handshake = bus.res_valid && bus.res_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         illegal       <= 1'b0;
         bus.alu_s     <= '0;
         bus.alu_a     <= '0;
         bus.alu_b     <= '0;
         bus.res_data  <= '0;
         bus.res_valid <= 1'b0;
         bus.res_err   <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  bus.alu_s <= bus.cmd_op;
                  bus.alu_a <= bus.cmd_a;
                  bus.alu_b <= bus.cmd_b;
                  cnt       <= bus.cmd_rep;
                  illegal   <= bus.cmd_op[3] & bus.cmd_op[2];
                  bus.busy  <= 1'b1;
                  state     <= EXEC;
               end
            end
            EXEC: begin
               // Illegal ops finish after a single EXEC cycle whatever cnt holds.
               if (illegal) begin
                  bus.res_data  <= '0;
                  bus.res_err   <= 1'b1;
                  bus.res_valid <= 1'b1;
                  state         <= HOLD;
               end else if (cnt != 4'd0) begin
                  bus.alu_a <= bus.alu_f;
                  cnt       <= cnt - 4'd1;
               end else begin
                  bus.res_data  <= bus.alu_f;
                  bus.res_err   <= 1'b0;
                  bus.res_valid <= 1'b1;
                  state         <= HOLD;
               end
            end
            HOLD: begin
               if (handshake) begin
                  bus.res_valid <= 1'b0;
                  // accept can only be true here when back-to-back issue is enabled.
                  if (accept) begin
                     bus.alu_s <= bus.cmd_op;
                     bus.alu_a <= bus.cmd_a;
                     bus.alu_b <= bus.cmd_b;
                     cnt       <= bus.cmd_rep;
                     illegal   <= bus.cmd_op[3] & bus.cmd_op[2];
                     state     <= EXEC;
                  end else begin
                     bus.busy <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end
            default: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_intercal_alu_seq.sv
// Directed self-checking bench for intercal_alu_seq; the bench also plays the external combinational ALU.
module tb_intercal_alu_seq;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   intercal_alu_seq_if bus ();

   intercal_alu_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream ALU: op 7 is a ^ rotr(a,1), op 1 passes b, op 0 adds.
   function automatic logic [31:0] alu_model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
      case (s)
         4'd0:    return a + b;
         4'd1:    return b;
         4'd2:    return a - b;
         4'd3:    return a & b;
         4'd4:    return a | b;
         4'd5:    return a ^ b;
         4'd6:    return ~a;
         4'd7:    return a ^ {a[0], a[31:1]};
         4'd8:    return a << 1;
         4'd9:    return a >> 1;
         4'd10:   return a;
         4'd11:   return b - a;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   always_comb bus.alu_f = alu_model(bus.alu_s, bus.alu_a, bus.alu_b);

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] rep);
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_rep   = rep;
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.alu_s !== 4'd0) begin failures++; $display("FAIL reset_alu_s: got %h expected 0", bus.alu_s); end
      checks++; if (bus.alu_a !== 32'd0) begin failures++; $display("FAIL reset_alu_a: got %h expected 0", bus.alu_a); end
      checks++; if (bus.alu_b !== 32'd0) begin failures++; $display("FAIL reset_alu_b: got %h expected 0", bus.alu_b); end
      checks++; if ({bus.res_valid, bus.res_err, bus.busy} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {bus.res_valid, bus.res_err, bus.busy}); end
      checks++; if (bus.res_data !== 32'd0) begin failures++; $display("FAIL reset_res_data: got %h expected 0", bus.res_data); end
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
   endtask

   task automatic test_single;
      int edges;
      bus.res_ready = 1'b1;
      issue(4'd7, 32'h0000_0001, 32'd0, 4'd0);
      checks++; if ({bus.cmd_ready, bus.busy} !== 2'b01) begin failures++; $display("FAIL single_exec_ready_busy: got %b expected 01", {bus.cmd_ready, bus.busy}); end
      checks++; if (bus.alu_s !== 4'd7 || bus.alu_a !== 32'h1) begin failures++; $display("FAIL single_latch: got s=%h a=%h expected s=7 a=00000001", bus.alu_s, bus.alu_a); end
      edges = 0;
      do begin @(posedge clk); #1; edges++; end while (!bus.res_valid && edges < 40);
      checks++; if (edges !== 1) begin failures++; $display("FAIL single_latency: got %0d expected 1", edges); end
      checks++; if (bus.res_data !== 32'h8000_0001) begin failures++; $display("FAIL single_data: got %h expected 80000001", bus.res_data); end
      checks++; if (bus.res_err !== 1'b0) begin failures++; $display("FAIL single_err: got %b expected 0", bus.res_err); end
      @(posedge clk);
      #1;
      checks++; if ({bus.res_valid, bus.busy, bus.cmd_ready} !== 3'b001) begin failures++; $display("FAIL single_after_hs: got %b expected 001", {bus.res_valid, bus.busy, bus.cmd_ready}); end
   endtask

   task automatic test_feedback;
      bus.res_ready = 1'b1;
      issue(4'd7, 32'h0000_0001, 32'd0, 4'd1);
      checks++; if (bus.alu_a !== 32'h0000_0001) begin failures++; $display("FAIL fb_exec1_alu_a: got %h expected 00000001", bus.alu_a); end
      @(posedge clk);
      #1;
      checks++; if (bus.alu_a !== 32'h8000_0001 || bus.res_valid !== 1'b0) begin failures++; $display("FAIL fb_exec2: got a=%h v=%b expected a=80000001 v=0", bus.alu_a, bus.res_valid); end
      @(posedge clk);
      #1;
      checks++; if (bus.res_valid !== 1'b1) begin failures++; $display("FAIL fb_latency: got valid=%b expected 1", bus.res_valid); end
      checks++; if (bus.res_data !== 32'h4000_0001) begin failures++; $display("FAIL fb_data: got %h expected 40000001", bus.res_data); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_illegal;
      int edges;
      bus.res_ready = 1'b1;
      issue(4'd13, 32'hFFFF_FFFF, 32'h5, 4'd15);
      edges = 0;
      do begin @(posedge clk); #1; edges++; end while (!bus.res_valid && edges < 40);
      checks++; if (edges !== 1) begin failures++; $display("FAIL illegal_latency: got %0d expected 1", edges); end
      checks++; if (bus.res_data !== 32'd0 || bus.res_err !== 1'b1) begin failures++; $display("FAIL illegal_result: got data=%h err=%b expected 0 and 1", bus.res_data, bus.res_err); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_hold;
      bus.res_ready = 1'b0;
      issue(4'd1, 32'h0, 32'h1234_ABCD, 4'd0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h1234_ABCD || bus.res_err !== 1'b0 ||
             bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL hold_cycle%0d: got v=%b d=%h e=%b rdy=%b busy=%b expected v=1 d=1234abcd e=0 rdy=0 busy=1",
                     i, bus.res_valid, bus.res_data, bus.res_err, bus.cmd_ready, bus.busy);
         end
         @(posedge clk);
         #1;
      end
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++; if ({bus.res_valid, bus.busy, bus.cmd_ready} !== 3'b001) begin failures++; $display("FAIL hold_release: got %b expected 001", {bus.res_valid, bus.busy, bus.cmd_ready}); end
   endtask

   task automatic test_reset_mid;
      logic seen;
      bus.res_ready = 1'b1;
      issue(4'd0, 32'd5, 32'd3, 4'd8);
      @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b1 || bus.alu_b !== 32'd3) begin failures++; $display("FAIL rstmid_pre: got busy=%b b=%h expected 1 and 3", bus.busy, bus.alu_b); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.alu_s !== 4'd0 || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.res_data !== 32'd0 ||
          bus.res_valid !== 1'b0 || bus.res_err !== 1'b0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_clear: got s=%h a=%h b=%h d=%h v=%b e=%b busy=%b expected all 0",
                  bus.alu_s, bus.alu_a, bus.alu_b, bus.res_data, bus.res_valid, bus.res_err, bus.busy);
      end
      #3 rst = 1'b0;
      seen = 1'b0;
      repeat (14) begin @(posedge clk); #1; if (bus.res_valid) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_no_result: got res_valid seen=%b expected 0", seen); end
      checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle: got rdy=%b busy=%b expected 1 0", bus.cmd_ready, bus.busy); end
   endtask

   task automatic test_back_to_back;
      int acc[2];
      int n_acc;
      int n_res;
      int exp_gap;
`ifdef INTERCAL_ALU_SEQ_PIPE_EN
      exp_gap = 2;
`else
      exp_gap = 3;
`endif
      n_acc = 0;
      n_res = 0;
      bus.res_ready = 1'b1;
      bus.cmd_op    = 4'd0;
      bus.cmd_a     = 32'd10;
      bus.cmd_b     = 32'd20;
      bus.cmd_rep   = 4'd0;
      bus.cmd_valid = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (bus.cmd_valid && bus.cmd_ready && n_acc < 2) begin
            acc[n_acc] = cyc;
            n_acc++;
         end
         if (bus.res_valid) begin
            n_res++;
            checks++; if (bus.res_data !== 32'd30) begin failures++; $display("FAIL b2b_data: got %h expected 0000001e", bus.res_data); end
         end
         @(posedge clk);
         #1;
         if (n_acc == 2) bus.cmd_valid = 1'b0;
      end
      checks++; if (n_acc !== 2) begin failures++; $display("FAIL b2b_accepts: got %0d expected 2", n_acc); end
      checks++; if (n_acc == 2 && (acc[1] - acc[0]) !== exp_gap) begin failures++; $display("FAIL b2b_gap: got %0d expected %0d", acc[1] - acc[0], exp_gap); end
      checks++; if (n_res !== 2) begin failures++; $display("FAIL b2b_results: got %0d expected 2", n_res); end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.cmd_rep   = '0;
      bus.res_ready = 1'b1;
      test_reset;
      test_single;
      test_feedback;
      test_illegal;
      test_hold;
      test_reset_mid;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
